// File: rtl/run_seq_if.sv
// run_seq_if: start/ready request and serial pattern output bundle for run_seq_gen
interface run_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] repeat_n;
  logic             ready;
  logic             x;
  logic             x_valid;
  logic [1:0]       run_len;
  logic             exp_y;
  logic             done;
  modport master (output start, data, repeat_n, input ready, x, x_valid, run_len, exp_y, done);
  modport slave  (input start, data, repeat_n, output ready, x, x_valid, run_len, exp_y, done);
endinterface

// File: rtl/run_seq_gen.sv
// run_seq_gen: MSB-first serial pattern transmitter with repeat count, bit stretching
// and an expected three-equal-bit run flag for the downstream detector.
module run_seq_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int DIV   = 1
) (
  input logic      clk,
  input logic      reset_n,
  run_seq_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(DIV + 1);
  localparam logic [BW-1:0] IDX_MAX  = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [DW-1:0]    div_q, div_d;
  logic [1:0]       run_len_q, run_len_d;
  logic             ready_q, ready_d, x_q, x_d, x_valid_q, x_valid_d, done_q, done_d;
  logic             last;
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pat_d     = pat_q;
    rep_d     = rep_q;
    bit_idx_d = bit_idx_q;
    div_d     = div_q;
    run_len_d = run_len_q;
    ready_d   = ready_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    done_d    = 1'b0;
    last      = div_q == DIV_LAST;
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d   = SEND;
        shift_d   = bus.data;
        pat_d     = bus.data;
        rep_d     = bus.repeat_n;
        bit_idx_d = IDX_MAX;
        div_d     = '0;
        ready_d   = 1'b0;
        x_valid_d = 1'b1;
        x_d       = bus.data[WIDTH-1];
        run_len_d = 2'd1;
      end
    end else if (state_q == SEND) begin
      div_d = last ? '0 : div_q + 1'b1;
      if (last) begin
        if (bit_idx_q != '0) begin
          shift_d   = shift_q << 1;
          bit_idx_d = bit_idx_q - 1'b1;
        end else if (rep_q != '0) begin
          shift_d   = pat_q;
          bit_idx_d = IDX_MAX;
          rep_d     = rep_q - 1'b1;
        end else begin
          state_d   = DONE;
          done_d    = 1'b1;
          x_valid_d = 1'b0;
        end
        // the run carries over pattern reloads; only leaving SEND clears it
        x_d       = (state_d == SEND) && shift_d[WIDTH-1];
        run_len_d = state_d != SEND ? 2'd0 :
                    shift_d[WIDTH-1] != x_q ? 2'd1 :
                    run_len_q == 2'd3 ? 2'd3 : run_len_q + 2'd1;
      end
    end else begin
      state_d = IDLE;
      ready_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      pat_q     <= '0;
      rep_q     <= '0;
      bit_idx_q <= '0;
      div_q     <= '0;
      run_len_q <= '0;
      ready_q   <= 1'b1;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      bit_idx_q <= bit_idx_d;
      div_q     <= div_d;
      run_len_q <= run_len_d;
      ready_q   <= ready_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end
  assign bus.ready   = ready_q;
  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.run_len = run_len_q;
  assign bus.done    = done_q;
  assign bus.exp_y   = x_valid_q && (run_len_q == 2'd3);
endmodule

// File: tb/tb_run_seq_gen.sv
// tb_run_seq_gen: scoreboard bench for run_seq_gen (DIV=1 and DIV=4 instances)
// plus a reference run detector checked against exp_y one cycle later.
module tb_run_seq_gen;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  run_seq_if #(.WIDTH(8), .CNT_W(4)) if1 ();
  run_seq_if #(.WIDTH(8), .CNT_W(4)) if4 ();
  run_seq_gen #(.WIDTH(8), .CNT_W(4), .DIV(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  run_seq_gen #(.WIDTH(8), .CNT_W(4), .DIV(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4.slave));
  typedef struct packed {logic x; logic [1:0] rl; logic ey;} exp_t;
  exp_t q1[$];
  exp_t q4[$];
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  function automatic void push_exp(input int sel, input logic [7:0] d, input int r, input int div);
    logic prev;
    int   rl;
    exp_t e;
    prev = 1'b0;
    rl   = 0;
    for (int p = 0; p <= r; p++)
      for (int i = 7; i >= 0; i--) begin
        rl   = (rl == 0) ? 1 : (d[i] == prev) ? (rl == 3 ? 3 : rl + 1) : 1;
        prev = d[i];
        e.x  = d[i];
        e.rl = rl[1:0];
        e.ey = (rl == 3);
        for (int k = 0; k < div; k++)
          if (sel == 4) q4.push_back(e); else q1.push_back(e);
      end
  endfunction
  function automatic logic rdy(input int sel);
    return sel == 4 ? if4.ready : if1.ready;
  endfunction
  function automatic logic dn(input int sel);
    return sel == 4 ? if4.done : if1.done;
  endfunction
  function automatic int qsize(input int sel);
    return sel == 4 ? q4.size() : q1.size();
  endfunction
  task automatic drive(input int sel, input logic s, input logic [7:0] d, input logic [3:0] r);
    if (sel == 4) begin
      if4.start = s; if4.data = d; if4.repeat_n = r;
    end else begin
      if1.start = s; if1.data = d; if1.repeat_n = r;
    end
  endtask
  task automatic chk_idle(input string name, input int sel);
    if (sel == 4) chk(name, {if4.ready, if4.x, if4.x_valid, if4.run_len, if4.exp_y, if4.done}, 7'b1000000);
    else          chk(name, {if1.ready, if1.x, if1.x_valid, if1.run_len, if1.exp_y, if1.done}, 7'b1000000);
  endtask
  // one transfer; glitch re-pulses start with data=0 in cycle 4, abort_at>0 drops reset in that cycle
  task automatic xfer(input int sel, input logic [7:0] d, input logic [3:0] r, input bit glitch, input int abort_at);
    int  div;
    int  c;
    bit  seen;
    div = (sel == 4) ? 4 : 1;
    c = 0;
    while (!rdy(sel) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("ready_before_start", rdy(sel), 1);
    push_exp(sel, d, r, div);
    drive(sel, 1'b1, d, r);
    @(posedge clk);
    #1 drive(sel, 1'b0, 8'h5A, 4'hF);
    seen = 1'b0;
    for (c = 1; c <= (r + 1) * 8 * div + 50 && !seen; c++) begin
      @(negedge clk);
      if (glitch && c == 4) drive(sel, 1'b1, 8'h00, 4'h0);
      if (glitch && c == 5) drive(sel, 1'b0, 8'h00, 4'h0);
      if (abort_at == c) begin
        #2 reset_n = 1'b0;
        #1 chk_idle("async_reset_outputs", sel);
        q1.delete();
        q4.delete();
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (dn(sel)) begin
        seen = 1'b1;
        chk("done_cycle", c, (r + 1) * 8 * div + 1);
        chk("ready_low_in_done", rdy(sel), 0);
        chk("queue_drained", qsize(sel), 0);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("ready_after_done", rdy(sel), 1);
    chk("no_done_after", dn(sel), 0);
  endtask
  always @(negedge clk) begin : mon1
    exp_t e;
    if (if1.x_valid) begin
      if (q1.size() == 0) chk("u1_unexpected_bit", 1, 0);
      else begin
        e = q1.pop_front();
        chk("u1_bit{x,run_len,exp_y}", {if1.x, if1.run_len, if1.exp_y}, e);
      end
    end
  end
  always @(negedge clk) begin : mon4
    exp_t e;
    if (if4.x_valid) begin
      if (q4.size() == 0) chk("u4_unexpected_bit", 1, 0);
      else begin
        e = q4.pop_front();
        chk("u4_bit{x,run_len,exp_y}", {if4.x, if4.run_len, if4.exp_y}, e);
      end
    end
  end
  // reference detector: y registered high when the current valid bit equals the previous two
  logic       h1, h2, det_y, last_ey;
  logic [1:0] hn;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h1 <= 1'b0; h2 <= 1'b0; hn <= 2'd0; det_y <= 1'b0;
    end else begin
      det_y <= if1.x_valid && hn == 2'd2 && if1.x == h1 && h1 == h2;
      h1    <= if1.x;
      h2    <= h1;
      hn    <= !if1.x_valid ? 2'd0 : hn == 2'd2 ? 2'd2 : hn + 2'd1;
    end
  end
  always @(negedge clk) begin : det_mon
    if (reset_n) chk("detector_alignment", det_y, last_ey);
    last_ey = reset_n ? if1.exp_y : 1'b0;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  initial begin
    drive(1, 1'b0, 8'h00, 4'h0);
    drive(4, 1'b0, 8'h00, 4'h0);
    repeat (3) @(negedge clk);
    chk_idle("reset_state_u1", 1);
    chk_idle("reset_state_u4", 4);
    reset_n = 1'b1;
    xfer(1, 8'hE3, 4'd0, 1'b0, 0);
    xfer(1, 8'hFF, 4'd2, 1'b0, 0);
    xfer(4, 8'hA5, 4'd0, 1'b0, 0);
    xfer(1, 8'hE3, 4'd0, 1'b1, 0);
    xfer(1, 8'hE3, 4'd0, 1'b0, 5);
    chk_idle("after_reset_release", 1);
    xfer(1, 8'h0F, 4'd0, 1'b0, 0);
    for (int t = 0; t < 64; t++) xfer(1, 8'($urandom), 4'($urandom_range(0, 15)), 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("final_queue_u1", q1.size(), 0);
    chk("final_queue_u4", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
